// File: rtl/if_id_queue.sv
// Two-entry fetch/decode skid queue holding {PC, NPC, IR}; flush empties it, rst clears everything.
// Optional zero-latency empty-queue forwarding path enabled by defining IFQ_BYPASS_EN.
module if_id_queue (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid_in,
  input  logic [31:0] if_PC_in,
  input  logic [31:0] if_NPC_in,
  input  logic [31:0] if_IR_in,
  input  logic        flush,
  input  logic        id_ready,
  output logic        if_ready_out,
  output logic        id_valid_out,
  output logic [31:0] id_PC_out,
  output logic [31:0] id_NPC_out,
  output logic [31:0] id_IR_out,
  output logic [1:0]  count_out
);

  localparam int DEPTH = 2;

  logic [31:0] r_pc  [DEPTH];
  logic [31:0] r_npc [DEPTH];
  logic [31:0] r_ir  [DEPTH];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;

  logic        w_push;
  logic        w_pop;
  logic        w_head_valid;

  // Ready depends only on registered occupancy, so a full queue stalls fetch even when decode pops.
  assign if_ready_out = (r_count < 2'd2);
  assign w_head_valid = (r_count != 2'd0);
  assign w_pop        = w_head_valid && id_ready && !flush;

`ifdef IFQ_BYPASS_EN
  logic w_bypass;
  // An empty queue whose consumer is ready hands the fetched word straight through without storing it.
  assign w_bypass = (r_count == 2'd0) && if_valid_in && id_ready && !flush;
  assign w_push   = if_valid_in && if_ready_out && !flush && !w_bypass;

  always_comb begin
    id_valid_out = w_head_valid;
    id_PC_out    = r_pc[r_rd_ptr];
    id_NPC_out   = r_npc[r_rd_ptr];
    id_IR_out    = r_ir[r_rd_ptr];
    if (w_bypass) begin
      id_valid_out = 1'b1;
      id_PC_out    = if_PC_in;
      id_NPC_out   = if_NPC_in;
      id_IR_out    = if_IR_in;
    end
  end
`else
  assign w_push       = if_valid_in && if_ready_out && !flush;
  assign id_valid_out = w_head_valid;
  assign id_PC_out    = r_pc[r_rd_ptr];
  assign id_NPC_out   = r_npc[r_rd_ptr];
  assign id_IR_out    = r_ir[r_rd_ptr];
`endif

  assign count_out = r_count;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          r_pc[gi]  <= 32'd0;
          r_npc[gi] <= 32'd0;
          r_ir[gi]  <= 32'd0;
        end else if (w_push && (r_wr_ptr == 1'(gi))) begin
          r_pc[gi]  <= if_PC_in;
          r_npc[gi] <= if_NPC_in;
          r_ir[gi]  <= if_IR_in;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reset, fill/refuse, flush, push+pop, rst while full, streaming.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid_in;
  logic [31:0] if_PC_in;
  logic [31:0] if_NPC_in;
  logic [31:0] if_IR_in;
  logic        flush;
  logic        id_ready;
  logic        if_ready_out;
  logic        id_valid_out;
  logic [31:0] id_PC_out;
  logic [31:0] id_NPC_out;
  logic [31:0] id_IR_out;
  logic [1:0]  count_out;

  int checks   = 0;
  int failures = 0;

  if_id_queue dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid_in  (if_valid_in),
    .if_PC_in     (if_PC_in),
    .if_NPC_in    (if_NPC_in),
    .if_IR_in     (if_IR_in),
    .flush        (flush),
    .id_ready     (id_ready),
    .if_ready_out (if_ready_out),
    .id_valid_out (id_valid_out),
    .id_PC_out    (id_PC_out),
    .id_NPC_out   (id_NPC_out),
    .id_IR_out    (id_IR_out),
    .count_out    (count_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
    $display("check %-14s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ir);
    if_valid_in = v;
    if_PC_in    = pc;
    if_NPC_in   = pc + 32'd4;
    if_IR_in    = ir;
  endtask

  initial begin
    int rx;
    rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick(); tick();
    rst = 1'b0;
    check("rst_valid", {31'd0, id_valid_out}, 32'd0);
    check("rst_pc",    id_PC_out,  32'h0);
    check("rst_npc",   id_NPC_out, 32'h0);
    check("rst_ir",    id_IR_out,  32'h0);
    check("rst_ready", {31'd0, if_ready_out}, 32'd1);
    check("rst_count", {30'd0, count_out}, 32'd0);

    // Single push with decode ready
    id_ready = 1'b1;
    drive(1'b1, 32'h0, 32'h11111111);
    #1;
`ifdef IFQ_BYPASS_EN
    check("byp_valid", {31'd0, id_valid_out}, 32'd1);
    check("byp_pc",    id_PC_out,  32'h0);
    check("byp_npc",   id_NPC_out, 32'h4);
    check("byp_ir",    id_IR_out,  32'h11111111);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("byp_count", {30'd0, count_out}, 32'd0);
`else
    check("p1_valid0", {31'd0, id_valid_out}, 32'd0);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    check("p1_valid",  {31'd0, id_valid_out}, 32'd1);
    check("p1_pc",     id_PC_out,  32'h0);
    check("p1_npc",    id_NPC_out, 32'h4);
    check("p1_ir",     id_IR_out,  32'h11111111);
    check("p1_count",  {30'd0, count_out}, 32'd1);
    tick();
    check("p1_popped", {30'd0, count_out}, 32'd0);
`endif

    // Fill with decode stalled; third push must be refused
    id_ready = 1'b0;
    drive(1'b1, 32'h0, 32'hA0); tick();
    drive(1'b1, 32'h4, 32'hA4); tick();
    check("full_count", {30'd0, count_out}, 32'd2);
    check("full_ready", {31'd0, if_ready_out}, 32'd0);
    drive(1'b1, 32'h8, 32'hA8); tick();
    drive(1'b0, 32'h0, 32'h0);
    check("refuse_cnt", {30'd0, count_out}, 32'd2);
    check("refuse_pc",  id_PC_out,  32'h0);
    check("refuse_ir",  id_IR_out,  32'hA0);

    // Flush beats a concurrent push
    flush = 1'b1;
    drive(1'b1, 32'h20, 32'hB0); tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush_count", {30'd0, count_out}, 32'd0);
    check("flush_valid", {31'd0, id_valid_out}, 32'd0);
    check("flush_ready", {31'd0, if_ready_out}, 32'd1);

    // Count 1 with simultaneous push and pop
    drive(1'b1, 32'h4, 32'h44); tick();
    check("c1_count", {30'd0, count_out}, 32'd1);
    check("c1_pc",    id_PC_out, 32'h4);
    id_ready = 1'b1;
    drive(1'b1, 32'h8, 32'h88); tick();
    drive(1'b0, 32'h0, 32'h0);
    id_ready = 1'b0;
    check("pp_count", {30'd0, count_out}, 32'd1);
    check("pp_pc",    id_PC_out,  32'h8);
    check("pp_npc",   id_NPC_out, 32'hC);
    check("pp_ir",    id_IR_out,  32'h88);

    // Reset while full overrides flush, push and pop
    drive(1'b1, 32'hC, 32'hCC); tick();
    check("f2_count", {30'd0, count_out}, 32'd2);
    rst = 1'b1; flush = 1'b1; id_ready = 1'b1;
    drive(1'b1, 32'h10, 32'hDD); tick();
    rst = 1'b0; flush = 1'b0; id_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("rst2_count", {30'd0, count_out}, 32'd0);
    check("rst2_valid", {31'd0, id_valid_out}, 32'd0);
    check("rst2_pc",    id_PC_out,  32'h0);
    check("rst2_npc",   id_NPC_out, 32'h0);
    check("rst2_ir",    id_IR_out,  32'h0);
    check("rst2_ready", {31'd0, if_ready_out}, 32'd1);

    // Ten back-to-back pushes streamed to a ready decoder
    rx = 0;
    id_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i < 10) drive(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i));
      else        drive(1'b0, 32'h0, 32'h0);
      #1;
      if (id_valid_out) begin
        check("strm_pc",  id_PC_out,  32'(rx * 4));
        check("strm_npc", id_NPC_out, 32'(rx * 4 + 4));
        check("strm_ir",  id_IR_out,  32'hA000_0000 + 32'(rx));
        rx++;
      end
      tick();
    end
    drive(1'b0, 32'h0, 32'h0);
    check("strm_total", 32'(rx), 32'd10);
    check("strm_empty", {30'd0, count_out}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
